sha256_pad: RTL and testbench
=============================

SHA256_PAD -- requirements
Module: sha256_pad

Interface
REQ-001 Parameter LEN_W, default 32: width of the message byte counter; legal range 4..61.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst_b  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  in_data holds a valid message byte.
REQ-005 in_data  input  8  message byte, in message order.
REQ-006 in_last  input  1  qualified by in_valid; marks the final byte of the message.
REQ-007 in_ready  output  1  the block accepts a byte this cycle.
REQ-008 blk_valid  output  1  blk holds a complete 512-bit block.
REQ-009 blk  output  512  block data; byte 0 sits at blk[511:504], word k at blk[511-32k -: 32].
REQ-010 blk_ready  input  1  the consumer takes the block this cycle.
REQ-011 blk_last  output  1  qualified by blk_valid; marks the final padded block of the message.

Function
REQ-012 A byte transfers when in_valid and in_ready are both 1; a block transfers when blk_valid and blk_ready are both 1.
REQ-013 The FSM has four states: ACCEPT, PAD, LENBLK and EMIT.
REQ-014 In ACCEPT, in_ready is 1; each accepted byte is written at byte index idx (0..64), then idx and the byte count cnt each increment.
REQ-015 In ACCEPT, when idx reaches 64, the FSM goes to EMIT with blk_last=0; it returns to PAD if the byte was last, otherwise to ACCEPT with idx cleared.
REQ-016 In ACCEPT, when a last byte leaves idx<64, the FSM goes to PAD on the next cycle.
REQ-017 PAD lasts one cycle: byte idx is set to 8'h80 and bytes idx+1..63 to 0.
REQ-018 From PAD with idx<=55: bytes 56..63 are set to the big-endian 64-bit value {cnt,3'b000}, and the FSM goes to EMIT with blk_last=1.
REQ-019 From PAD with idx>=56: the FSM goes to EMIT with blk_last=0 and return state LENBLK.
REQ-020 LENBLK lasts one cycle: the block becomes 448 zero bits followed by the 64-bit length, and the FSM goes to EMIT with blk_last=1.
REQ-021 In EMIT, blk_valid is 1 and in_ready is 0; blk and blk_last stay stable until the transfer.
REQ-022 On the final transfer in EMIT, idx, cnt and the block register clear and the FSM goes to ACCEPT.
REQ-023 Latency: blk_valid rises two cycles after a last byte with idx<=55 is accepted (one cycle for PAD, then EMIT).
REQ-024 Zero-length messages are not supported; every message carries at least one byte with in_last.
REQ-025 The length arithmetic is zero-extended to 64 bits; cnt wraps modulo 2^LEN_W.

Reset
REQ-026 While rst_b=0, the FSM is in ACCEPT with idx=0, cnt=0 and blk=0.
REQ-027 While rst_b=0, in_ready=0, blk_valid=0 and blk_last=0.
REQ-028 in_ready rises on the first clock edge after rst_b deasserts.
REQ-029 A reset mid-message or mid-EMIT discards the partial message and any pending block.

Configuration
REQ-030 With SHA256_PAD_OVF_EN defined, an output ovf (1 bit) exists; it is reset to 0, set sticky when cnt wraps, and cleared on the final block transfer.
REQ-031 Without SHA256_PAD_OVF_EN, port ovf and its logic are absent and the wrap is silent.

Structure
REQ-032 Package sha256_pkg holds: the FSM state enum, BLK_W=512, LEN_FIELD_W=64 and PAD_BYTE=8'h80.
REQ-033 The 512-bit block register is an instance of the existing rgst sub-module (w=512).
REQ-034 Byte insertion and length insertion are combinational logic feeding rgst.d.

Verification
REQ-035 "abc" (61,62,63, last) with blk_ready=1 -> one block, blk_last=1: blk[511:480]=32'h61626380, blk[63:0]=64'h18, all other bits 0.
REQ-036 55 bytes of 8'h00 -> one block: byte 55=8'h80, blk[63:0]=64'h1B8, blk_last=1.
REQ-037 56 bytes -> two blocks: block 1 has byte 56=8'h80 with blk_last=0; block 2 is all zeros except blk[63:0]=64'h1C0, with blk_last=1.
REQ-038 64 bytes -> two blocks: block 1 is the raw data with blk_last=0; block 2 has byte 0=8'h80 and blk[63:0]=64'h200, with blk_last=1.
REQ-039 blk_ready held 0 for 10 cycles during EMIT -> blk stable and in_ready=0 throughout; exactly one transfer follows.
REQ-040 Reset after 20 bytes, then "abc" -> output identical to REQ-035.
REQ-041 With LEN_W=6 and SHA256_PAD_OVF_EN defined, a 70-byte message -> ovf=1 after the 64th byte; ovf=0 after the final transfer.

Source files
------------

// File: rtl/sha256_pad_pkg.sv
// sha256_pkg: shared FSM state type, block/length geometry and byte-lane helper for sha256_pad.
package sha256_pkg;
  typedef enum logic [1:0] {ACCEPT, PAD, LENBLK, EMIT} state_t;
  localparam int BLK_W = 512;
  localparam int LEN_FIELD_W = 64;
  localparam logic [7:0] PAD_BYTE = 8'h80;
  // Left-shift that moves a byte from bit 0 up to byte lane i (byte 0 is the MSB lane).
  function automatic logic [8:0] byte_sh(input logic [5:0] i);
    return {~i, 3'b000};
  endfunction
endpackage

// File: rtl/sha256_pad_if.sv
// sha256_pad_if: byte-in / 512-bit-block-out handshake bundle for sha256_pad.
interface sha256_pad_if;
  import sha256_pkg::*;
  logic in_valid;
  logic [7:0] in_data;
  logic in_last;
  logic in_ready;
  logic blk_valid;
  logic [BLK_W-1:0] blk;
  logic blk_ready;
  logic blk_last;
  modport master(output in_valid, in_data, in_last, blk_ready, input in_ready, blk_valid, blk, blk_last);
  modport slave(input in_valid, in_data, in_last, blk_ready, output in_ready, blk_valid, blk, blk_last);
endinterface

// File: rtl/sha256_pad_rgst.sv
// rgst: plain w-bit register with asynchronous active-low clear.
module rgst #(parameter int w = 8) (
  input  logic         clk,
  input  logic         rst_b,
  input  logic [w-1:0] d,
  output logic [w-1:0] q
);
  always_ff @(posedge clk or negedge rst_b)
    if (!rst_b) q <= '0;
    else q <= d;
endmodule

// File: rtl/sha256_pad.sv
// sha256_pad: packs message bytes into 512-bit SHA-256 blocks and appends 0x80, zero fill and 64-bit bit length.
// Define SHA256_PAD_OVF_EN to add the sticky ovf output flagging a byte-counter wrap.
module sha256_pad import sha256_pkg::*; #(parameter int LEN_W = 32) (
  input logic clk,
  input logic rst_b,
  sha256_pad_if.slave bus
`ifdef SHA256_PAD_OVF_EN
  , output logic ovf
`endif
);
  state_t state, state_n, ret, ret_n;
  logic [6:0] idx, idx_n;
  logic [LEN_W-1:0] cnt, cnt_n;
  logic last_q, last_n, run, acc, xfer, emit, short;
  logic [BLK_W-1:0] q, d, ins, pad, padl;
  logic [LEN_FIELD_W-1:0] len;
  logic [8:0] bsh, ksh;
  assign emit = state == EMIT;
  assign bus.in_ready = run && state == ACCEPT;
  assign bus.blk_valid = emit;
  assign bus.blk = q;
  assign bus.blk_last = emit && last_q;
  assign acc = bus.in_valid && bus.in_ready;
  assign xfer = emit && bus.blk_ready;
  assign len = LEN_FIELD_W'({cnt, 3'b000});
  assign bsh = byte_sh(idx[5:0]);
  assign ksh = {idx[5:0], 3'b000};
  assign short = idx <= 7'd55;
  assign ins = (q & ~(BLK_W'(8'hFF) << bsh)) | (BLK_W'(bus.in_data) << bsh);
  // Keep bytes 0..idx-1, place the pad marker at idx, zero everything after it.
  assign pad = (q & ~({BLK_W{1'b1}} >> ksh)) | (BLK_W'(PAD_BYTE) << bsh);
  assign padl = {pad[BLK_W-1:LEN_FIELD_W], len};
  rgst #(.w(BLK_W)) u_blk (.clk(clk), .rst_b(rst_b), .d(d), .q(q));
  always_ff @(posedge clk or negedge rst_b)
    if (!rst_b) begin
      state <= ACCEPT;
      ret <= ACCEPT;
      idx <= '0;
      cnt <= '0;
      last_q <= 1'b0;
      run <= 1'b0;
    end else begin
      state <= state_n;
      ret <= ret_n;
      idx <= idx_n;
      cnt <= cnt_n;
      last_q <= last_n;
      run <= 1'b1;
    end
  always_comb begin
    state_n = state;
    ret_n = ret;
    idx_n = idx;
    cnt_n = cnt;
    last_n = last_q;
    d = q;
    unique case (state)
      ACCEPT: if (acc) begin
        d = ins;
        idx_n = idx + 7'd1;
        cnt_n = cnt + LEN_W'(1);
        state_n = (idx == 7'd63) ? EMIT : bus.in_last ? PAD : ACCEPT;
        ret_n = bus.in_last ? PAD : ACCEPT;
        last_n = 1'b0;
      end
      PAD: begin
        d = short ? padl : pad;
        state_n = EMIT;
        last_n = short;
        ret_n = short ? ACCEPT : LENBLK;
      end
      LENBLK: begin
        d = BLK_W'(len);
        state_n = EMIT;
        last_n = 1'b1;
        ret_n = ACCEPT;
      end
      EMIT: if (xfer) begin
        d = '0;
        idx_n = '0;
        state_n = ret;
        cnt_n = last_q ? '0 : cnt;
      end
    endcase
  end
`ifdef SHA256_PAD_OVF_EN
  always_ff @(posedge clk or negedge rst_b)
    if (!rst_b) ovf <= 1'b0;
    else if (acc && &cnt) ovf <= 1'b1;
    else if (xfer && last_q) ovf <= 1'b0;
`endif
endmodule

// File: tb/tb_sha256_pad.sv
// tb_sha256_pad: scoreboard bench for sha256_pad at LEN_W=32 and a lockstep LEN_W=6 copy; ovf checked when SHA256_PAD_OVF_EN is defined.
module tb_sha256_pad;
  logic clk = 1'b0;
  logic rst_b = 1'b0;
  int vecs = 0;
  int errs = 0;
  int xfers = 0;
  logic [511:0] lastblk;
  logic [512:0] q32[$];
  logic [512:0] q6[$];
  logic ovf32, ovf6;
  always #5 clk = ~clk;
  sha256_pad_if bus();
  sha256_pad_if b6();
  assign b6.in_valid = bus.in_valid;
  assign b6.in_data = bus.in_data;
  assign b6.in_last = bus.in_last;
  assign b6.blk_ready = bus.blk_ready;
  sha256_pad #(.LEN_W(32)) u0 (.clk(clk), .rst_b(rst_b), .bus(bus)
`ifdef SHA256_PAD_OVF_EN
    , .ovf(ovf32)
`endif
  );
  sha256_pad #(.LEN_W(6)) u6 (.clk(clk), .rst_b(rst_b), .bus(b6)
`ifdef SHA256_PAD_OVF_EN
    , .ovf(ovf6)
`endif
  );
  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  // Reference padding: 0x80, zeros to 56 mod 64, then the bit length (mod 2^32 and mod 2^6).
  task automatic push_exp(input logic [7:0] m[$]);
    logic [7:0] p[$];
    logic [511:0] v;
    int n, nb;
    bit l;
    n = m.size();
    p = m;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    repeat (8) p.push_back(8'h00);
    nb = p.size() / 64;
    for (int b = 0; b < nb; b++) begin
      v = '0;
      for (int j = 0; j < 64; j++) v[511-8*j -: 8] = p[64*b+j];
      l = b == nb - 1;
      q32.push_back({l, v | (l ? 512'(64'(n) * 8) : 512'd0)});
      q6.push_back({l, v | (l ? 512'(64'(n % 64) * 8) : 512'd0)});
    end
  endtask
  task automatic send(input logic [7:0] m[$], input bit fin, input bit push);
    bit ok;
    int g;
    if (push) push_exp(m);
    for (int i = 0; i < m.size(); i++) begin
      bus.in_valid = 1'b1;
      bus.in_data = m[i];
      bus.in_last = fin && i == m.size() - 1;
      ok = 1'b0;
      g = 0;
      while (!ok && g < 300) begin
        @(negedge clk);
        ok = bus.in_ready;
        @(posedge clk);
        #1;
        g++;
      end
      if (!ok) begin
        chk("in_timeout", 0, 1);
        break;
      end
`ifdef SHA256_PAD_OVF_EN
      if (m.size() == 70 && i == 62) chk("ovf_pre", ovf6, 0);
      if (m.size() == 70 && i == 63) chk("ovf_set", ovf6, 1);
`endif
    end
    bus.in_valid = 1'b0;
    bus.in_last = 1'b0;
  endtask
  task automatic drain();
    int g = 0;
    while (q32.size() != 0 && g < 300) begin
      @(posedge clk);
      g++;
    end
    chk("drain", q32.size(), 0);
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_b = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_last = 1'b0;
    #2;
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_blk_valid", bus.blk_valid, 0);
    chk("rst_blk_last", bus.blk_last, 0);
    chk("rst_blk", bus.blk, 0);
    repeat (2) @(negedge clk);
    rst_b = 1'b1;
    #1;
    chk("rel_in_ready_lo", bus.in_ready, 0);
    @(posedge clk);
    #1;
    chk("rel_in_ready_hi", bus.in_ready, 1);
  endtask
  always @(negedge clk)
    if (rst_b && bus.blk_valid && bus.blk_ready) begin
      logic [512:0] e;
      xfers++;
      lastblk = bus.blk;
      if (q32.size() == 0) chk("extra_blk", 1, 0);
      else begin
        e = q32.pop_front();
        chk("blk", bus.blk, e[511:0]);
        chk("blk_last", bus.blk_last, e[512]);
      end
      if (q6.size() == 0) chk("extra_blk6", 1, 0);
      else begin
        e = q6.pop_front();
        chk("blk6_valid", b6.blk_valid, 1);
        chk("blk6", b6.blk, e[511:0]);
        chk("blk6_last", b6.blk_last, e[512]);
      end
    end
  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    logic [7:0] m[$];
    logic [511:0] h;
    int x0, g;
    bus.in_valid = 1'b0;
    bus.in_data = 8'h00;
    bus.in_last = 1'b0;
    bus.blk_ready = 1'b1;
    do_reset();
    m = '{8'h61, 8'h62, 8'h63};
    send(m, 1, 1);
    drain();
    chk("abc_w0", lastblk[511:480], 32'h61626380);
    chk("abc_len", lastblk[63:0], 64'h18);
    m.delete();
    repeat (55) m.push_back(8'h00);
    send(m, 1, 1);
    drain();
    chk("b55_pad", lastblk[71:64], 8'h80);
    chk("b55_len", lastblk[63:0], 64'h1B8);
    for (int n = 56; n <= 64; n += 8) begin
      m.delete();
      for (int i = 0; i < n; i++) m.push_back(8'(i + 1));
      send(m, 1, 1);
      drain();
    end
    chk("b64_len", lastblk[63:0], 64'h200);
    chk("b64_pad", lastblk[511:504], 8'h80);
    m.delete();
    for (int i = 0; i < 70; i++) m.push_back(8'($urandom_range(0, 255)));
    send(m, 1, 1);
    drain();
`ifdef SHA256_PAD_OVF_EN
    chk("ovf_clr", ovf6, 0);
    chk("ovf32", ovf32, 0);
`endif
    bus.blk_ready = 1'b0;
    m = '{8'h61, 8'h62, 8'h63};
    send(m, 1, 1);
    chk("lat_pad", bus.blk_valid, 0);
    @(posedge clk);
    #1;
    chk("lat_emit", bus.blk_valid, 1);
    h = bus.blk;
    x0 = xfers;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("stall_blk", bus.blk, h);
      chk("stall_in_ready", bus.in_ready, 0);
    end
    @(posedge clk);
    #1;
    bus.blk_ready = 1'b1;
    repeat (5) @(posedge clk);
    chk("stall_one_xfer", xfers - x0, 1);
    drain();
    bus.blk_ready = 1'b0;
    send(m, 1, 0);
    g = 0;
    while (!bus.blk_valid && g < 20) begin
      @(posedge clk);
      #1;
      g++;
    end
    chk("emit_seen", bus.blk_valid, 1);
    do_reset();
    bus.blk_ready = 1'b1;
    m.delete();
    for (int i = 0; i < 20; i++) m.push_back(8'hA5);
    send(m, 0, 0);
    do_reset();
    x0 = xfers;
    m = '{8'h61, 8'h62, 8'h63};
    send(m, 1, 1);
    drain();
    chk("rst_abc_xfers", xfers - x0, 1);
    chk("rst_abc_w0", lastblk[511:480], 32'h61626380);
    chk("rst_abc_len", lastblk[63:0], 64'h18);
    chk("q6_empty", q6.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
